// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight: IDLE grants and latches, EXEC captures the ALU result, RESP holds it until consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_beq,
  output logic             resp_bne,
  output logic             resp_bgt,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [2:0]       alu_select,
  input  logic [WIDTH-1:0] alu_output1,
  input  logic             alu_beq,
  input  logic             alu_bne,
  input  logic             alu_bgt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             beq_q, beq_d;
  logic             bne_q, bne_d;
  logic             bgt_q, bgt_d;
  logic             err_q, err_d;

  logic pick;
  logic any_valid;
  logic div_zero;
  logic resp_taken;

  // On a tie the requester not granted last time wins; a lone requester always wins.
  assign pick       = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign any_valid  = req0_valid | req1_valid;
  assign div_zero   = (op_q == 3'd7) && (b_q == '0);
  assign resp_taken = gnt_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    res_d   = res_q;
    beq_d   = beq_q;
    bne_d   = bne_q;
    bgt_d   = bgt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = EXEC;
          gnt_d   = pick;
          last_d  = pick;
          a_d     = pick ? req1_a  : req0_a;
          b_d     = pick ? req1_b  : req0_b;
          op_d    = pick ? req1_op : req0_op;
        end
      end
      EXEC: begin
        state_d = RESP;
        res_d   = div_zero ? '0 : alu_output1;
        err_d   = div_zero;
        beq_d   = alu_beq;
        bne_d   = alu_bne;
        bgt_d   = alu_bgt;
      end
      RESP: begin
        if (resp_taken) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
      beq_q   <= 1'b0;
      bne_q   <= 1'b0;
      bgt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      res_q   <= res_d;
      beq_q   <= beq_d;
      bne_q   <= bne_d;
      bgt_q   <= bgt_d;
      err_q   <= err_d;
    end
  end

  // Ready is masked while rst is high so no handshake appears to complete during reset.
  assign req0_ready  = !rst && (state_q == IDLE) && req0_valid && !pick;
  assign req1_ready  = !rst && (state_q == IDLE) && req1_valid && pick;
  assign resp0_valid = (state_q == RESP) && !gnt_q;
  assign resp1_valid = (state_q == RESP) && gnt_q;
  assign resp_result = res_q;
  assign resp_beq    = beq_q;
  assign resp_bne    = bne_q;
  assign resp_bgt    = bgt_q;
  assign resp_err    = err_q;
  assign alu_input1  = a_q;
  assign alu_input2  = b_q;
  assign alu_select  = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: provides the shared ALU, drives directed and random transactions, and checks against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_beq, resp_bne, resp_bgt, resp_err;
  logic [31:0] alu_input1, alu_input2, alu_output1;
  logic [2:0]  alu_select;
  logic        alu_beq, alu_bne, alu_bgt;

  int errors = 0;
  int checks = 0;
  int last_g = 1;

  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [2:0]  pop [2];
  logic        pv [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return 32'd0;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return a * b;
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  assign alu_output1 = ref_alu(alu_select, alu_input1, alu_input2);
  assign alu_beq     = (alu_input1 == alu_input2);
  assign alu_bne     = (alu_input1 != alu_input2);
  assign alu_bgt     = (alu_input1 > alu_input2);

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_beq(resp_beq), .resp_bne(resp_bne),
    .resp_bgt(resp_bgt), .resp_err(resp_err),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_select(alu_select),
    .alu_output1(alu_output1), .alu_beq(alu_beq), .alu_bne(alu_bne), .alu_bgt(alu_bgt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
    req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    pv[id] = 1'b1; pop[id] = op; pa[id] = a; pb[id] = b;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk1({tag, "_resp0_valid"}, resp0_valid, 1'b0);
    chk1({tag, "_resp1_valid"}, resp1_valid, 1'b0);
    chk({tag, "_result"}, resp_result, 32'd0);
    chk1({tag, "_beq"}, resp_beq, 1'b0);
    chk1({tag, "_bne"}, resp_bne, 1'b0);
    chk1({tag, "_bgt"}, resp_bgt, 1'b0);
    chk1({tag, "_err"}, resp_err, 1'b0);
    chk({tag, "_alu_in1"}, alu_input1, 32'd0);
    chk({tag, "_alu_in2"}, alu_input2, 32'd0);
    chk({tag, "_alu_sel"}, {29'd0, alu_select}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv[0] = 1'b0; pv[1] = 1'b0;
    apply();
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    last_g = 1;
  endtask

  // One complete transaction from IDLE: grant, EXEC, RESP held for `hold` extra cycles, then consume.
  task automatic do_txn(input int hold);
    int g;
    logic [31:0] a, b, er;
    logic [2:0]  op;
    logic        ee;
    apply();
    #3;
    g = (pv[0] && pv[1]) ? 1 - last_g : (pv[1] ? 1 : 0);
    last_g = g;
    chk1("grant_req0_ready", req0_ready, g == 0);
    chk1("grant_req1_ready", req1_ready, g == 1);
    a = pa[g]; b = pb[g]; op = pop[g];
    ee = (op == 3'd7) && (b == 32'd0);
    er = ee ? 32'd0 : ref_alu(op, a, b);
    tick();
    pv[g] = 1'b0;
    apply();
    chk1("exec_req0_ready", req0_ready, 1'b0);
    chk1("exec_req1_ready", req1_ready, 1'b0);
    chk1("exec_resp0_valid", resp0_valid, 1'b0);
    chk1("exec_resp1_valid", resp1_valid, 1'b0);
    chk("exec_alu_in1", alu_input1, a);
    chk("exec_alu_in2", alu_input2, b);
    chk("exec_alu_sel", {29'd0, alu_select}, {29'd0, op});
    tick();
    for (int i = 0; i <= hold; i++) begin
      chk1("resp_resp0_valid", resp0_valid, g == 0);
      chk1("resp_resp1_valid", resp1_valid, g == 1);
      chk("resp_result", resp_result, er);
      chk1("resp_beq", resp_beq, a == b);
      chk1("resp_bne", resp_bne, a != b);
      chk1("resp_bgt", resp_bgt, a > b);
      chk1("resp_err", resp_err, ee);
      chk1("resp_req0_ready", req0_ready, 1'b0);
      chk1("resp_req1_ready", req1_ready, 1'b0);
      if (g == 0) begin
        resp0_ready = (i == hold);
        resp1_ready = 1'($urandom_range(0, 1));
      end else begin
        resp1_ready = (i == hold);
        resp0_ready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    chk1("done_resp0_valid", resp0_valid, 1'b0);
    chk1("done_resp1_valid", resp1_valid, 1'b0);
  endtask

  task automatic new_random_req(input int id);
    logic [31:0] a, b;
    a = $urandom;
    case ($urandom_range(0, 4))
      0: b = 32'd0;
      1: b = a;
      default: b = $urandom;
    endcase
    set_req(id, 3'($urandom_range(0, 7)), a, b);
  endtask

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    do_reset();

    // Single add, then equal-operand add.
    set_req(0, 3'd4, 32'd5, 32'd7);
    do_txn(0);
    set_req(0, 3'd4, 32'd8, 32'd8);
    do_txn(0);

    // Both requesters held continuously: grants alternate starting with req0.
    do_reset();
    set_req(0, 3'd5, 32'd9, 32'd4);
    set_req(1, 3'd3, 32'hF0, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      do_txn(0);
      if (i % 2 == 0) set_req(0, 3'd5, 32'd9, 32'd4);
      else set_req(1, 3'd3, 32'hF0, 32'h0F);
    end
    pv[0] = 1'b0; pv[1] = 1'b0;

    // Divide by zero, then a normal divide.
    set_req(1, 3'd7, 32'd10, 32'd0);
    do_txn(0);
    set_req(1, 3'd7, 32'd10, 32'd3);
    do_txn(1);

    // Response back-pressure with the other requester waiting.
    set_req(0, 3'd1, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    set_req(1, 3'd2, 32'h1234_0000, 32'h0000_5678);
    do_txn(5);
    do_txn(0);

    // Reset while a multiply is in EXEC: aborted, no response afterwards.
    set_req(0, 3'd6, 32'd6, 32'd7);
    apply();
    #3;
    chk1("abort_req0_ready", req0_ready, 1'b1);
    tick();
    chk("abort_exec_alu_in1", alu_input1, 32'd6);
    rst = 1'b1;
    tick();
    check_zero("abort");
    rst = 1'b0;
    pv[0] = 1'b0;
    apply();
    last_g = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("abort_no_resp0", resp0_valid, 1'b0);
      chk1("abort_no_resp1", resp1_valid, 1'b0);
    end

    // Randomized traffic; pending requests keep valid held until granted.
    for (int t = 0; t < 80; t++) begin
      for (int id = 0; id < 2; id++)
        if (!pv[id] && $urandom_range(0, 1) == 1) new_random_req(id);
      if (!pv[0] && !pv[1]) new_random_req(int'($urandom_range(0, 1)));
      do_txn(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; the block SHALL support only 32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  32 each  operands A and B per requester.
REQ-006 req0_op, req1_op  input  3 each  ALU select per requester: 0 zero, 1 and, 2 or, 3 xor, 4 add, 5 sub, 6 mul, 7 div.
REQ-007 req0_ready, req1_ready  output  1 each  request accepted this cycle when high with valid.
REQ-008 resp0_valid, resp1_valid  output  1 each  result available for requester N.
REQ-009 resp0_ready, resp1_ready  input  1 each  requester N consumes the response.
REQ-010 resp_result  output  32  captured ALU result; resp_beq, resp_bne, resp_bgt  output  1 each  captured flags; resp_err  output  1  divide-by-zero.
REQ-011 alu_input1, alu_input2  output  32; alu_select  output  3  drive the shared ALU.
REQ-012 alu_output1  input  32; alu_beq, alu_bne, alu_bgt  input  1 each  shared ALU results (combinational).

Function
REQ-013 FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-014 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one requester, assert that reqN_ready combinationally the same cycle, latch its a, b, op and grant ID, and go to EXEC.
REQ-015 reqN_ready SHALL be low in EXEC and RESP, and low for the non-granted requester.
REQ-016 Both valid in IDLE: grant SHALL go to the requester not granted most recently (round-robin); last-grant pointer resets to 1, so req0 wins the first tie.
REQ-017 Only one valid: that requester SHALL be granted regardless of pointer; pointer updates to the granted ID at acceptance.
REQ-018 alu_input1/alu_input2/alu_select SHALL be driven from the latched registers at all times; latched registers and ALU drive SHALL reset to 0.
REQ-019 In EXEC (exactly one cycle), the block SHALL capture alu_output1 and the three flags into response registers and go to RESP.
REQ-020 op 7 with latched b == 0: resp_result SHALL be 0, resp_err 1, flags still captured from the ALU; otherwise resp_err 0.
REQ-021 In RESP, respN_valid SHALL be high only for the granted ID; response data SHALL remain stable until respN_ready is sampled high with it.
REQ-022 respN_ready high in RESP for the granted ID -> next cycle IDLE with resp valid low; the other requester's resp_ready SHALL be ignored.
REQ-023 Latency: accept at edge T -> respN_valid high from cycle T+2; minimum issue interval 3 cycles.
REQ-024 Requests arriving in EXEC/RESP SHALL be held off (ready low) and served from IDLE per REQ-016; no request SHALL be dropped while valid is held.

Reset
REQ-025 rst high at a rising edge SHALL force IDLE, last-grant=1, both reqN_ready low, both respN_valid low, resp_result/flags/resp_err 0, ALU drive 0, regardless of state.
REQ-026 Reset in EXEC or RESP SHALL abort the in-flight operation with no response issued.

Verification
REQ-027 req0 add a=5 b=7, resp0_ready=1 -> req0_ready high at accept, resp0_valid at T+2, resp_result=12, resp_bne=1, resp_beq=0, resp_err=0.
REQ-028 Both valid continuously after reset (req0 sub 9-4, req1 xor F0^0F) -> grants 0,1,0,1 alternate; resp_result 5 then 0xFF.
REQ-029 req1 div a=10 b=0 -> resp1_valid, resp_result=0, resp_err=1; then div 10/3 -> result 3, resp_err=0.
REQ-030 resp0_ready held low 5 cycles in RESP -> resp0_valid and resp_result stable, no new grant, req1_ready low throughout.
REQ-031 rst asserted during EXEC of req0 mul 6*7 -> next cycle all outputs 0, IDLE, no resp0_valid ever asserted for that op.
REQ-032 req0 op 4 a=8 b=8 -> resp_result=16, resp_beq=1, resp_bne=0, resp_bgt equal to alu_bgt observed during EXEC.
